// File: rtl/gr_file_mp.sv
// -----------------------------------------------------------------------------
// gr_file_mp : general-register file for the CPU core
//
// Purpose:
//   NREG x XLEN register array with NRP combinational read ports, two write
//   ports (w1 beats w0 on a shared destination), write-through bypass to every
//   read port, and a per-register busy scoreboard.
//   - Issue sets busy.
//   - Writeback clears busy.
//   - Decode uses rs_busy to detect RAW hazards.
//
// Ports:
//   clk      in   clock, all state changes on the rising edge
//   reset    in   synchronous active-low reset
//   rs       in   NRP x AW read indices
//   x_rs     out  NRP x XLEN read data (combinational, bypassed)
//   rs_busy  out  NRP busy flags for the indexed registers (combinational)
//   w0_*     in   write port 0 (slow writeback, lower priority)
//   w1_*     in   write port 1 (ALU writeback, higher priority)
//   iss_en   in   issue strobe, marks iss_rd busy
//   iss_rd   in   issued destination index
//   busy_any out  OR of all stored busy bits (no bypass)
//
// Configuration:
//   GR_ZERO_REG_EN - when defined, register 0 is hardwired to zero and can
//                    never become busy. When undefined, register 0 is ordinary.
// -----------------------------------------------------------------------------
module gr_file_mp #(
    parameter  int XLEN = 32,
    parameter  int NREG = 16,
    parameter  int NRP  = 2,
    localparam int AW   = $clog2(NREG)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NRP-1:0][AW-1:0]    rs,
    output logic [NRP-1:0][XLEN-1:0]  x_rs,
    output logic [NRP-1:0]            rs_busy,
    input  logic                      w0_en,
    input  logic [AW-1:0]             w0_rd,
    input  logic [XLEN-1:0]           w0_data,
    input  logic                      w1_en,
    input  logic [AW-1:0]             w1_rd,
    input  logic [XLEN-1:0]           w1_data,
    input  logic                      iss_en,
    input  logic [AW-1:0]             iss_rd,
    output logic                      busy_any
);

    logic [XLEN-1:0] r_regs [NREG];
    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_nxt;

    // Effective enables: with the zero register enabled, anything aimed at
    // index 0 is dropped here so array, bypass and scoreboard all ignore it.
    logic w_w0_ok;
    logic w_w1_ok;
    logic w_iss_ok;

`ifdef GR_ZERO_REG_EN
    assign w_w0_ok  = w0_en  && (w0_rd  != {AW{1'b0}});
    assign w_w1_ok  = w1_en  && (w1_rd  != {AW{1'b0}});
    assign w_iss_ok = iss_en && (iss_rd != {AW{1'b0}});
`else
    assign w_w0_ok  = w0_en;
    assign w_w1_ok  = w1_en;
    assign w_iss_ok = iss_en;
`endif

    // Register array update: reset clears everything, w1 overrides w0 on the same rd.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int r = 0; r < NREG; r++) begin
                r_regs[r] <= {XLEN{1'b0}};
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (w_w1_ok && (w1_rd == AW'(r))) begin
                    r_regs[r] <= w1_data;
                end else if (w_w0_ok && (w0_rd == AW'(r))) begin
                    r_regs[r] <= w0_data;
                end else begin
                    r_regs[r] <= r_regs[r];
                end
            end
        end
    end

    // Scoreboard next state: a new issue outranks a writeback clear, because
    // the issue names a newer producer for the register.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int r = 0; r < NREG; r++) begin
            if (w_iss_ok && (iss_rd == AW'(r))) begin
                w_busy_nxt[r] = 1'b1;
            end else if ((w_w0_ok && (w0_rd == AW'(r))) ||
                         (w_w1_ok && (w1_rd == AW'(r)))) begin
                w_busy_nxt[r] = 1'b0;
            end else begin
                w_busy_nxt[r] = r_busy[r];
            end
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_busy <= {NREG{1'b0}};
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    // Read ports.
    // Data shows the post-edge value.
    // Busy has a clear-bypass only, so a same-cycle issue shows up one cycle later.
    always_comb begin
        x_rs    = '0;
        rs_busy = '0;
        for (int i = 0; i < NRP; i++) begin
            if (w_w1_ok && (w1_rd == rs[i])) begin
                x_rs[i] = w1_data;
            end else if (w_w0_ok && (w0_rd == rs[i])) begin
                x_rs[i] = w0_data;
            end else begin
                x_rs[i] = r_regs[rs[i]];
            end

            if (w_iss_ok && (iss_rd == rs[i])) begin
                rs_busy[i] = r_busy[rs[i]];
            end else if ((w_w0_ok && (w0_rd == rs[i])) ||
                         (w_w1_ok && (w1_rd == rs[i]))) begin
                rs_busy[i] = 1'b0;
            end else begin
                rs_busy[i] = r_busy[rs[i]];
            end
        end
    end

    assign busy_any = |r_busy;

endmodule

// File: tb/tb_gr_file_mp.sv
module tb_gr_file_mp;

    localparam int XLEN = 32;
    localparam int NREG = 16;
    localparam int NRP  = 2;
    localparam int AW   = 4;

    logic                      clk;
    logic                      reset;
    logic [NRP-1:0][AW-1:0]    rs;
    logic [NRP-1:0][XLEN-1:0]  x_rs;
    logic [NRP-1:0]            rs_busy;
    logic                      w0_en;
    logic [AW-1:0]             w0_rd;
    logic [XLEN-1:0]           w0_data;
    logic                      w1_en;
    logic [AW-1:0]             w1_rd;
    logic [XLEN-1:0]           w1_data;
    logic                      iss_en;
    logic [AW-1:0]             iss_rd;
    logic                      busy_any;

    int n_cmp = 0;
    int n_err = 0;

    gr_file_mp #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP)) dut (
        .clk      (clk),
        .reset    (reset),
        .rs       (rs),
        .x_rs     (x_rs),
        .rs_busy  (rs_busy),
        .w0_en    (w0_en),
        .w0_rd    (w0_rd),
        .w0_data  (w0_data),
        .w1_en    (w1_en),
        .w1_rd    (w1_rd),
        .w1_data  (w1_data),
        .iss_en   (iss_en),
        .iss_rd   (iss_rd),
        .busy_any (busy_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // advance one edge, leave time for outputs to settle away from the edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        w0_en = 1'b0; w1_en = 1'b0; iss_en = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b0; rs = '0;
        w0_en = 1'b0; w0_rd = '0; w0_data = '0;
        w1_en = 1'b0; w1_rd = '0; w1_data = '0;
        iss_en = 1'b0; iss_rd = '0;
        tick(); tick();
        reset = 1'b1;
        #1;

        // populate r3/r5, busy r3
        w0_en = 1'b1; w0_rd = 4'd3; w0_data = 32'h0000_0033;
        w1_en = 1'b1; w1_rd = 4'd5; w1_data = 32'h0000_0055;
        iss_en = 1'b1; iss_rd = 4'd3;
        tick(); idle();
        rs[0] = 4'd3; rs[1] = 4'd5; #1;
        chk("pre_rst_r3", x_rs[0], 32'h0000_0033);
        chk("pre_rst_r5", x_rs[1], 32'h0000_0055);
        chk("pre_rst_busy3", {31'd0, rs_busy[0]}, 32'd1);
        chk("pre_rst_busy_any", {31'd0, busy_any}, 32'd1);

        // reset overrides a same-cycle write and issue
        reset = 1'b0;
        w1_en = 1'b1; w1_rd = 4'd3; w1_data = 32'h0000_0099;
        iss_en = 1'b1; iss_rd = 4'd5;
        tick(); reset = 1'b1; idle();
        chk("rst_x0", x_rs[0], 32'h0);
        chk("rst_x1", x_rs[1], 32'h0);
        chk("rst_busy", {30'd0, rs_busy}, 32'd0);
        chk("rst_busy_any", {31'd0, busy_any}, 32'd0);

        // w1 write with bypass, then stored value
        w1_en = 1'b1; w1_rd = 4'd5; w1_data = 32'hDEAD_BEEF;
        rs[0] = 4'd5; rs[1] = 4'd6; #1;
        chk("byp_r5", x_rs[0], 32'hDEAD_BEEF);
        chk("byp_r6_unaff", x_rs[1], 32'h0);
        tick(); idle();
        chk("store_r5", x_rs[0], 32'hDEAD_BEEF);

        // same-rd collision: w1 wins
        w0_en = 1'b1; w0_rd = 4'd7; w0_data = 32'h1111_1111;
        w1_en = 1'b1; w1_rd = 4'd7; w1_data = 32'h2222_2222;
        rs[1] = 4'd7; #1;
        chk("coll_byp", x_rs[1], 32'h2222_2222);
        tick(); idle();
        chk("coll_store", x_rs[1], 32'h2222_2222);

        // different rd: both land
        w0_en = 1'b1; w0_rd = 4'd8;  w0_data = 32'h0000_0088;
        w1_en = 1'b1; w1_rd = 4'd10; w1_data = 32'h0000_00AA;
        rs[0] = 4'd8; rs[1] = 4'd10; #1;
        chk("dual_byp_w0", x_rs[0], 32'h0000_0088);
        chk("dual_byp_w1", x_rs[1], 32'h0000_00AA);
        tick(); idle();
        chk("dual_r8", x_rs[0], 32'h0000_0088);
        chk("dual_r10", x_rs[1], 32'h0000_00AA);
        rs[1] = 4'd8; #1;
        chk("same_idx", x_rs[1], 32'h0000_0088);

        // scoreboard: issue r4, set visible next cycle
        iss_en = 1'b1; iss_rd = 4'd4; rs[0] = 4'd4; #1;
        chk("iss_same_cyc", {31'd0, rs_busy[0]}, 32'd0);
        chk("iss_same_any", {31'd0, busy_any}, 32'd0);
        tick(); idle();
        chk("iss_next", {31'd0, rs_busy[0]}, 32'd1);
        chk("iss_next_any", {31'd0, busy_any}, 32'd1);
        tick(); tick(); tick();
        chk("iss_hold", {31'd0, rs_busy[0]}, 32'd1);
        // writeback clears with bypass, busy_any still registered
        w0_en = 1'b1; w0_rd = 4'd4; w0_data = 32'h0000_005A; #1;
        chk("clr_byp", {31'd0, rs_busy[0]}, 32'd0);
        chk("clr_byp_any", {31'd0, busy_any}, 32'd1);
        tick(); idle();
        chk("clr_store", {31'd0, rs_busy[0]}, 32'd0);
        chk("clr_any", {31'd0, busy_any}, 32'd0);
        chk("clr_data", x_rs[0], 32'h0000_005A);

        // set/clear collision on busy r9
        iss_en = 1'b1; iss_rd = 4'd9; rs[0] = 4'd9;
        tick(); idle();
        chk("r9_busy", {31'd0, rs_busy[0]}, 32'd1);
        iss_en = 1'b1; iss_rd = 4'd9;
        w1_en = 1'b1; w1_rd = 4'd9; w1_data = 32'h0000_0909; #1;
        chk("r9_coll_view", {31'd0, rs_busy[0]}, 32'd1);
        tick(); idle();
        chk("r9_coll_after", {31'd0, rs_busy[0]}, 32'd1);
        chk("r9_data", x_rs[0], 32'h0000_0909);

        // re-issue to a busy register keeps it busy; write then clears
        iss_en = 1'b1; iss_rd = 4'd9;
        tick(); idle();
        chk("r9_reiss", {31'd0, rs_busy[0]}, 32'd1);
        w0_en = 1'b1; w0_rd = 4'd9; w0_data = 32'h0000_0001;
        tick(); idle();
        chk("r9_free", {31'd0, rs_busy[0]}, 32'd0);
        chk("r9_free_any", {31'd0, busy_any}, 32'd0);

        // register 0 behaviour
        w1_en = 1'b1; w1_rd = 4'd0; w1_data = 32'hFFFF_FFFF;
        iss_en = 1'b1; iss_rd = 4'd0; rs[0] = 4'd0; #1;
`ifdef GR_ZERO_REG_EN
        chk("r0_byp", x_rs[0], 32'h0);
`else
        chk("r0_byp", x_rs[0], 32'hFFFF_FFFF);
`endif
        chk("r0_busy_cyc", {31'd0, rs_busy[0]}, 32'd0);
        tick(); idle();
`ifdef GR_ZERO_REG_EN
        chk("r0_store", x_rs[0], 32'h0);
        chk("r0_busy_next", {31'd0, rs_busy[0]}, 32'd0);
        chk("r0_busy_any", {31'd0, busy_any}, 32'd0);
`else
        chk("r0_store", x_rs[0], 32'hFFFF_FFFF);
        chk("r0_busy_next", {31'd0, rs_busy[0]}, 32'd1);
        chk("r0_busy_any", {31'd0, busy_any}, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/gr_file_mp.md
Name: gr_file_mp

Overview:
- Parametrised general-register file for the CPU core: configurable data width, register count and number of read ports.
- Two write ports with fixed priority and write-through bypass to all read ports.
- Per-register busy scoreboard, set at instruction issue and cleared at writeback, so decode can detect RAW hazards on operands.
- Sits between decode/issue (read, issue) and the writeback stages (write ports).

Parameters:
- XLEN, 32: register data width in bits.
- NREG, 16: number of registers; must be a power of two, at least 2.
- NRP, 2: number of read ports, 1..4.
- AW (localparam): clog2(NREG), register index width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- rs  in  NRP x AW  read-port register indices.
- x_rs  out  NRP x XLEN  read data, combinational.
- rs_busy  out  NRP  busy flag of each indexed register, combinational.
- w0_en  in  1  write port 0 enable (late/slow writeback).
- w0_rd  in  AW  write port 0 destination index.
- w0_data  in  XLEN  write port 0 data.
- w1_en  in  1  write port 1 enable (ALU writeback, higher priority).
- w1_rd  in  AW  write port 1 destination index.
- w1_data  in  XLEN  write port 1 data.
- iss_en  in  1  issue: mark iss_rd busy.
- iss_rd  in  AW  issued destination index.
- busy_any  out  1  OR of all busy bits.

Behaviour:
- Reset:
  - Sampled on rising clk while reset==0.
  - All registers clear to 0 and all busy bits clear to 0.
  - Reset overrides any write or issue in the same cycle.
  - Outputs after reset: x_rs all 0, rs_busy all 0, busy_any 0.
- Write:
  - On a rising edge with reset==1, each enabled port writes its data into its rd.
  - Both ports enabled to the same rd: w1 wins, w0 is discarded.
  - Different rd: both writes land in the same cycle.
- Read:
  - Fully combinational, zero latency.
  - x_rs[i] is the value the register will hold after the current edge (write-through bypass):
    - if w1_en and w1_rd==rs[i], return w1_data;
    - else if w0_en and w0_rd==rs[i], return w0_data;
    - else return the stored value.
  - Reads on different ports are independent; the same index on several ports returns identical data.
- Scoreboard, one busy bit per register, next-state per register r:
  - Set: iss_en and iss_rd==r.
  - Clear: (w0_en and w0_rd==r) or (w1_en and w1_rd==r).
  - Set and clear in the same cycle: set wins, because a new producer was issued.
  - Otherwise the bit holds.
- rs_busy[i]:
  - Reflects the stored busy bit with a clear-bypass: it is 0 if a write to rs[i] occurs this cycle.
  - Exception: iss_en targets rs[i] in the same cycle. Then rs_busy[i] shows the stored bit only; the new set becomes visible the following cycle.
- busy_any: OR of stored busy bits, registered view with no bypass.
- Misuse:
  - Issuing to an already-busy register is legal; the bit simply stays 1.
  - A write to a non-busy register is legal.
- No handshake back-pressure: writes always complete in one cycle.

Optional Feature:
- Macro GR_ZERO_REG_EN.
- Defined:
  - Register 0 is hardwired to zero. Writes to index 0 are discarded, including the bypass path, so x_rs returns 0 for rs==0.
  - Issue to index 0 does not set busy, and busy[0] is constant 0.
- Not defined: register 0 behaves like every other register.

Test Plan:
- Reset: after writes to r3 and r5 plus issue to r3, hold reset=0 for one edge -> x_rs all 0, rs_busy all 0, busy_any=0.
- Write/read: w1 writes r5=0xDEADBEEF at edge N; from the cycle after edge N, rs[0]=5 returns 0xDEADBEEF. In the cycle before edge N, the bypass already returns 0xDEADBEEF.
- Write collision: w0 writes r7=0x11111111 and w1 writes r7=0x22222222 in the same cycle -> r7 = 0x22222222 after the edge, and the bypass shows 0x22222222 in that cycle.
- Scoreboard:
  - Issue r4 at cycle 1 -> rs_busy=1 for rs=4 from cycle 2, busy_any=1.
  - w0 writes r4=0x5A at cycle 5 -> rs_busy=0 during cycle 5 (bypass), stored bit 0 from cycle 6.
- Set/clear collision: r9 busy; same cycle iss_rd=9 and w1_rd=9 -> busy[9] stays 1 after the edge.
- With GR_ZERO_REG_EN: w1 writes r0=0xFFFFFFFF and issue r0 -> x_rs=0 and rs_busy=0 for rs=0 in both the write cycle and the next cycle. Without the macro, r0 reads 0xFFFFFFFF.
